tmds_decode: RTL and testbench
==============================

# tmds_decode

Receive-side TMDS channel decoder for the HDMI path. It is the inverse of the team's `encode` block. Per channel, it takes one word-aligned 10-bit TMDS symbol per `vga_clk` from the deserializer and produces:
- the 8-bit pixel byte,
- `hsync`/`vsync` (c0/c1),
- a data-enable.

It also runs a word-alignment state machine that requests bit-slips from the deserializer until control-token runs are found, and reports lock. Three instances (B/G/R) sit between the deserializer and the downstream video timing/capture logic.

## Interface
Parameters:
- `CTRL_RUN`, default 32: consecutive control tokens required to declare a valid blanking run.
- `TIMEOUT`, default 4096: cycles allowed without a completed run before slipping (SEARCH) or dropping lock (LOCKED).
- `SLIP_WAIT`, default 8: settle cycles after each `bitslip` pulse.

Ports:
- `vga_clk`  in  1: pixel clock; the only clock.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  10: aligned TMDS symbol, bit 0 = first serial bit.
- `data_out`  out  8: decoded pixel byte.
- `hsync`  out  1: decoded c0.
- `vsync`  out  1: decoded c1.
- `rgb_valid`  out  1: data-enable, gated by `locked`.
- `locked`  out  1: alignment achieved.
- `bitslip`  out  1: one-cycle request to the deserializer to shift word boundary by one bit.

## Operation
Control tokens use this codebase's encoder bit ordering, with {c1,c0}:
- 00 = 10'h0AB
- 01 = 10'h354
- 10 = 10'h0AA
- 11 = 10'h355

Pipeline:
- **Stage 1:** register `data_in` as `sym_r`. Flag `is_ctrl` = `sym_r` matches any of the four control tokens.
- **Stage 2, control token:** `data_out` = 0, `rgb_valid` = 0, `{vsync,hsync}` = decoded token.
- **Stage 2, data symbol:** `q` = `sym_r[9]` ? ~`sym_r[7:0]` : `sym_r[7:0]`.
  - `d[0]` = `q[0]`.
  - For i = 1..7: `d[i]` = `q[i]`^`q[i-1]` if `sym_r[8]`=1, else ~(`q[i]`^`q[i-1]`).
  - `data_out` = `d`, `rgb_valid` = `locked_next`.
  - `hsync`/`vsync` hold their previous values.

Run/timer logic operates on stage 1:
- `run_cnt` increments on `is_ctrl`, clears on non-control, and saturates at `CTRL_RUN`.
- A run "completes" on the cycle `run_cnt` transitions to `CTRL_RUN`.
- `tmr` counts up every cycle. It clears on run completion and on every state entry.

States (reset state is SEARCH):
- **SEARCH:**
  - Run completes → LOCKED.
  - `tmr` reaches `TIMEOUT`-1 → SLIP.
- **SLIP:** `bitslip`=1 for exactly one cycle, then → WAIT. `run_cnt` clears.
- **WAIT:** `SLIP_WAIT` cycles with `run_cnt` held at 0, then → SEARCH.
- **LOCKED:**
  - `tmr` reaches `TIMEOUT`-1 → SEARCH. `locked` falls; no slip is issued from LOCKED.
  - Each run completion clears `tmr`.

Boundary rules:
- If run completion and timer expiry coincide, completion wins.
- `tmr` and `run_cnt` widths are $clog2(param+1). Neither wraps.
- Non-token, non-decodable misaligned words are still decoded. Correctness is signalled only by `locked`.

## Timing
- **Reset values:** all outputs 0; state SEARCH; counters 0.
- **Reset mid-operation:** takes effect immediately and returns to reset values, including dropping `locked` and `bitslip`.
- **Data latency:** 2 cycles. A symbol presented before edge k appears on `data_out`/`hsync`/`vsync`/`rgb_valid` after edge k+1.
- **`locked`:** rises at the same edge where the outputs for the `CTRL_RUN`-th consecutive token appear. It therefore stays aligned with the data pipeline.
- **`bitslip`:** never asserted in consecutive cycles. Minimum spacing between pulses is 1 + `SLIP_WAIT` + `TIMEOUT` cycles.

## Structure
- Shared package/include `tmds_pkg`, also used by `encode`, holds:
  - the four control-token constants,
  - the {c1,c0} mapping,
  - the state encodings.
- One natural sub-module: `tmds_align_fsm`. It contains `run_cnt`, `tmr` and the state machine, takes `is_ctrl`, and outputs `locked`/`bitslip`.
- The decode datapath stays in the top.

## Test plan
1. **Reset:** assert `sys_rst_n`=0 mid-stream → all outputs 0 immediately. After release, `locked`=0 and state is SEARCH.
2. **Lock:** drive 10'h354 for 32 cycles.
   - `hsync`=1, `vsync`=0, `rgb_valid`=0 from cycle 2.
   - `locked`=1 at the edge the 32nd token's outputs appear.
   - Then 10'h0AA → `vsync`=1, `hsync`=0.
3. **Data decode while locked:**
   - 10'h100 → `data_out`=8'h00.
   - 10'h200 → 8'hFF.
   - Both with `rgb_valid`=1 two cycles later.
   - Also round-trip 256 bytes through `encode` → every byte is recovered.
4. **Slip sequence:** random non-token data from reset.
   - `bitslip` pulses one cycle at cycle `TIMEOUT`.
   - Next pulse comes exactly `SLIP_WAIT`+1+`TIMEOUT` cycles later.
   - `locked` stays 0.
5. **Loss of lock:** after locking, feed data only for `TIMEOUT` cycles.
   - `locked` falls at expiry.
   - `rgb_valid` goes to 0 on the same edge.
   - No `bitslip` pulse in that cycle.
6. **Boundary:** a run completing on the exact `TIMEOUT`-1 cycle in SEARCH → LOCKED, no `bitslip`. A run of 31 tokens, one data word, then 31 tokens → no lock.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encode and decode blocks.
// Holds the control tokens, the {c1,c0} mapping and the alignment state encodings.
package tmds_pkg;

    // Control tokens in this codebase's encoder bit ordering, indexed by {c1,c0}
    localparam logic [9:0] CTRL_TOKEN_00 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h0AA;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h355;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    // Result of matching a symbol against the control-token alphabet
    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] cv;         // {c1,c0}
    } ctrl_info_t;

    function automatic ctrl_info_t ctrl_decode(input logic [9:0] sym);
        ctrl_info_t info;
        info = '0;
        case (sym)
            CTRL_TOKEN_00: begin info.is_ctrl = 1'b1; info.cv = 2'b00; end
            CTRL_TOKEN_01: begin info.is_ctrl = 1'b1; info.cv = 2'b01; end
            CTRL_TOKEN_10: begin info.is_ctrl = 1'b1; info.cv = 2'b10; end
            CTRL_TOKEN_11: begin info.is_ctrl = 1'b1; info.cv = 2'b11; end
            default:       info = '0;
        endcase
        return info;
    endfunction

    function automatic logic [9:0] ctrl_encode(input logic [1:0] cv);
        logic [9:0] tok;
        case (cv)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment controller: counts control-token runs, requests bit-slips
// while searching, and reports lock. Timer doubles as the WAIT settle counter,
// so SLIP_WAIT must not exceed TIMEOUT.
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN  = 32,
    parameter int TIMEOUT   = 4096,
    parameter int SLIP_WAIT = 8
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic is_ctrl,
    output logic locked,
    output logic locked_next,
    output logic bitslip
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    align_state_t     state_reg, state_next;
    logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             locked_reg, bitslip_reg;
    logic             counting, run_done, tmr_expired, wait_done;

    // Run completion and timer conditions; completion only counts while runs are being tracked
    always_comb begin
        counting    = (state_reg == ST_SEARCH) || (state_reg == ST_LOCKED);
        run_done    = counting && is_ctrl && (run_cnt_reg == RUN_W'(CTRL_RUN - 1));
        tmr_expired = (tmr_reg == TMR_W'(TIMEOUT - 1));
        wait_done   = (tmr_reg == TMR_W'(SLIP_WAIT - 1));
    end

    // Next-state decision; a completing run beats a coinciding timer expiry
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SEARCH: begin
                if (run_done)         state_next = ST_LOCKED;
                else if (tmr_expired) state_next = ST_SLIP;
            end
            ST_SLIP:   state_next = ST_WAIT;
            ST_WAIT:   if (wait_done) state_next = ST_SEARCH;
            ST_LOCKED: if (!run_done && tmr_expired) state_next = ST_SEARCH;
            default:   state_next = ST_SEARCH;
        endcase
    end

    // Saturating run counter (held at zero around a slip) and saturating timer
    always_comb begin
        run_cnt_next = run_cnt_reg;
        if (!counting || !is_ctrl)
            run_cnt_next = '0;
        else if (run_cnt_reg != RUN_W'(CTRL_RUN))
            run_cnt_next = run_cnt_reg + 1'b1;

        tmr_next = tmr_reg;
        if ((state_next != state_reg) || run_done)
            tmr_next = '0;
        else if (tmr_reg != TMR_W'(TIMEOUT))
            tmr_next = tmr_reg + 1'b1;
    end

    // State, counters and registered outputs
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_SEARCH;
            run_cnt_reg <= '0;
            tmr_reg     <= '0;
            locked_reg  <= 1'b0;
            bitslip_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
            tmr_reg     <= tmr_next;
            locked_reg  <= (state_next == ST_LOCKED);
            bitslip_reg <= (state_next == ST_SLIP);
        end
    end

    assign locked      = locked_reg;
    assign locked_next = (state_next == ST_LOCKED);
    assign bitslip     = bitslip_reg;

endmodule

// File: rtl/tmds_decode.sv
// Per-channel TMDS receive decoder: two-stage pipeline recovering the pixel
// byte, c0/c1 and data-enable, plus the word-alignment controller.
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN  = 32,
    parameter int TIMEOUT   = 4096,
    parameter int SLIP_WAIT = 8
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] data_in,
    output logic [7:0] data_out,
    output logic       hsync,
    output logic       vsync,
    output logic       rgb_valid,
    output logic       locked,
    output logic       bitslip
);

    logic [9:0] sym_reg;
    ctrl_info_t ctrl;
    logic [7:0] q;
    logic [7:0] d;
    logic       locked_next;
    logic [7:0] data_out_reg;
    logic       hsync_reg, vsync_reg, rgb_valid_reg;

    // Stage 1: capture the aligned symbol
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sym_reg <= '0;
        else            sym_reg <= data_in;
    end

    assign ctrl = ctrl_decode(sym_reg);

    // Undo the optional inversion, then the XOR/XNOR transition chain
    assign q    = sym_reg[9] ? ~sym_reg[7:0] : sym_reg[7:0];
    assign d[0] = q[0];

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_chain
            assign d[gi] = sym_reg[8] ? (q[gi] ^ q[gi-1]) : ~(q[gi] ^ q[gi-1]);
        end
    endgenerate

    tmds_align_fsm #(
        .CTRL_RUN  (CTRL_RUN),
        .TIMEOUT   (TIMEOUT),
        .SLIP_WAIT (SLIP_WAIT)
    ) u_align (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .is_ctrl     (ctrl.is_ctrl),
        .locked      (locked),
        .locked_next (locked_next),
        .bitslip     (bitslip)
    );

    // Stage 2: register decoded outputs; syncs only change on control tokens
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_out_reg  <= '0;
            hsync_reg     <= 1'b0;
            vsync_reg     <= 1'b0;
            rgb_valid_reg <= 1'b0;
        end else if (ctrl.is_ctrl) begin
            data_out_reg  <= '0;
            rgb_valid_reg <= 1'b0;
            hsync_reg     <= ctrl.cv[0];
            vsync_reg     <= ctrl.cv[1];
        end else begin
            data_out_reg  <= d;
            rgb_valid_reg <= locked_next;
        end
    end

    assign data_out  = data_out_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign rgb_valid = rgb_valid_reg;

endmodule

// File: tb/tb_tmds_decode.sv
// Directed bench for tmds_decode with a scoreboard of expected pipeline outputs.
module tb_tmds_decode;

    localparam int CTRL_RUN  = 32;
    localparam int TIMEOUT   = 512;
    localparam int SLIP_WAIT = 8;

    logic       vga_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [9:0] data_in   = '0;
    logic [7:0] data_out;
    logic       hsync, vsync, rgb_valid, locked, bitslip;

    always #5 vga_clk = ~vga_clk;

    tmds_decode #(
        .CTRL_RUN  (CTRL_RUN),
        .TIMEOUT   (TIMEOUT),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb_valid (rgb_valid),
        .locked    (locked),
        .bitslip   (bitslip)
    );

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       h, v, rv, lk;
    } exp_t;

    exp_t sb[$];
    int   slip_cyc[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_h  = 1'b0;
    logic exp_v  = 1'b0;
    bit   slip_allowed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_token(input logic [9:0] s);
        return (s == 10'h0AB) || (s == 10'h354) || (s == 10'h0AA) || (s == 10'h355);
    endfunction

    // {c1,c0} carried by each token
    function automatic logic [1:0] token_cv(input logic [9:0] s);
        case (s)
            10'h354: return 2'b01;
            10'h0AA: return 2'b10;
            10'h355: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Reference TMDS data encoder; inversion choice is supplied by the caller
    function automatic logic [9:0] enc(input logic [7:0] d, input bit inv);
        logic [8:0] qm;
        logic [9:0] s;
        int         ones;
        bit         use_xnor;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        if (is_token(s)) s = {~inv, qm[8], inv ? qm[7:0] : ~qm[7:0]};
        return s;
    endfunction

    // Drive one symbol, queue its expected outputs, advance one clock, compare due entries
    task automatic step(input logic [9:0] sym, input bit chk, input logic [7:0] e_byte, input bit e_lk);
        exp_t e;
        data_in = sym;
        if (is_token(sym)) {exp_v, exp_h} = token_cv(sym);
        if (chk) begin
            e.due  = cyc + 2;
            e.data = is_token(sym) ? 8'h00 : e_byte;
            e.rv   = is_token(sym) ? 1'b0 : e_lk;
            e.h    = exp_h;
            e.v    = exp_v;
            e.lk   = e_lk;
            sb.push_back(e);
        end
        @(posedge vga_clk);
        cyc++;
        #1;
        if (bitslip) slip_cyc.push_back(cyc);
        if (!slip_allowed) check("no_bitslip", 32'(bitslip), 32'd0);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("data_out",  32'(data_out),  32'(e.data));
            check("hsync",     32'(hsync),     32'(e.h));
            check("vsync",     32'(vsync),     32'(e.v));
            check("rgb_valid", 32'(rgb_valid), 32'(e.rv));
            check("locked",    32'(locked),    32'(e.lk));
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_hsync",     32'(hsync),     32'd0);
        check("rst_vsync",     32'(vsync),     32'd0);
        check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_bitslip",   32'(bitslip),   32'd0);
        sb.delete();
        slip_cyc.delete();
        exp_h = 1'b0;
        exp_v = 1'b0;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        sys_rst_n = 1'b1;
        cyc = 0;
        check("post_rst_locked", 32'(locked), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [9:0] s;
        int         lock_edge;
        int         first, gap;

        // Lock on 32 c0=1 tokens, then switch to c1=1 tokens
        do_reset();
        for (int i = 1; i <= CTRL_RUN; i++) step(10'h354, 1'b1, 8'h00, i == CTRL_RUN);
        lock_edge = CTRL_RUN + 1;
        for (int i = 0; i < 4; i++) step(10'h0AA, 1'b1, 8'h00, 1'b1);

        // Data decode while locked, including a full byte round trip
        step(10'h100, 1'b1, 8'h00, 1'b1);
        step(10'h200, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            step(enc(b, 1'($urandom)), 1'b1, b, 1'b1);
        end

        // Data only until the lock timer expires; no slip may follow
        while (cyc + 2 < lock_edge + TIMEOUT + 4) begin
            b = 8'($urandom);
            step(enc(b, 1'($urandom)), 1'b1, b, (cyc + 2) < (lock_edge + TIMEOUT));
        end

        // Relock, stream pixels, then reset mid-stream
        for (int i = 1; i <= CTRL_RUN; i++) step(10'h355, 1'b1, 8'h00, i == CTRL_RUN);
        for (int i = 0; i < 3; i++) step(10'h200, 1'b1, 8'hFF, 1'b1);
        do_reset();

        // Random data from reset: slip pulses and their spacing
        slip_allowed = 1'b1;
        while (cyc < 2 * TIMEOUT + SLIP_WAIT + 5) begin
            b = 8'($urandom);
            step(enc(b, 1'($urandom)), 1'b1, b, 1'b0);
        end
        first = (slip_cyc.size() > 0) ? slip_cyc[0] : -1;
        gap   = (slip_cyc.size() > 1) ? (slip_cyc[1] - slip_cyc[0]) : -1;
        check("slip_count", 32'(slip_cyc.size()), 32'd2);
        check("slip_first", 32'(first), 32'(TIMEOUT));
        check("slip_gap",   32'(gap),   32'(1 + SLIP_WAIT + TIMEOUT));
        slip_allowed = 1'b0;

        // Run completing on the timer's last SEARCH cycle locks instead of slipping
        do_reset();
        for (int i = 1; i <= TIMEOUT - CTRL_RUN - 1; i++) begin
            b = 8'($urandom);
            step(enc(b, 1'($urandom)), 1'b1, b, 1'b0);
        end
        for (int i = 1; i <= CTRL_RUN; i++) step(10'h355, 1'b1, 8'h00, i == CTRL_RUN);
        for (int i = 0; i < 3; i++) step(10'h355, 1'b1, 8'h00, 1'b1);

        // 31 tokens, a data word, 31 tokens: no lock; one more token completes the run
        do_reset();
        for (int i = 0; i < CTRL_RUN - 1; i++) step(10'h354, 1'b1, 8'h00, 1'b0);
        s = enc(8'h5A, 1'b0);
        step(s, 1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < CTRL_RUN - 1; i++) step(10'h354, 1'b1, 8'h00, 1'b0);
        step(10'h354, 1'b1, 8'h00, 1'b1);
        step(10'h200, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) step(10'h100, 1'b0, 8'h00, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
